// File: rtl/fetch_decode_if.sv
// fetch_decode_if: fetch-to-decode pipeline register contents.
interface fetch_decode_if;
  logic [31:0] instruction;
  logic [31:0] instr_npc;
  modport fetch (output instruction, instr_npc);
  modport decode (input instruction, instr_npc);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction request and a one-word skid buffer feeding the decode latch.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 en,
  input  logic                 jump_instr,
  input  logic [31:0]          jump_target,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 halt,
  output logic                 imemREN,
  output logic [31:0]          imemaddr,
  input  logic                 ihit,
  input  logic [31:0]          imemload,
  fetch_decode_if.fetch        out
);
  typedef enum logic [1:0] {FETCH, BUF, HALTED} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_word_q, buf_word_d, buf_npc_q, buf_npc_d;
  logic [31:0] instr_q, instr_d, npc_q, npc_d;
  logic        buf_valid_q, buf_valid_d;
  logic        redirect, fetch_hit, avail;
  logic [31:0] target, pc_plus4, avail_word, avail_npc;
  assign redirect   = en & (branch_taken | jump_instr);
  assign target     = branch_taken ? branch_target : jump_target;
  assign pc_plus4   = pc_q + 32'd4;
  assign fetch_hit  = (state_q == FETCH) & ihit;
  assign avail      = fetch_hit | ((state_q == BUF) & buf_valid_q);
  assign avail_word = fetch_hit ? imemload : buf_word_q;
  assign avail_npc  = fetch_hit ? pc_plus4 : buf_npc_q;
  assign imemREN    = state_q == FETCH;
  assign imemaddr   = pc_q;
  assign out.instruction = instr_q;
  assign out.instr_npc   = npc_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_word_d  = buf_word_q;
    buf_npc_d   = buf_npc_q;
    buf_valid_d = buf_valid_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    if (state_q == HALTED) begin
      if (en) begin
        instr_d = '0;
        npc_d   = '0;
      end
    end else if (redirect || (en && halt)) begin
      pc_d        = redirect ? target : pc_q;
      state_d     = redirect ? FETCH : HALTED;
      buf_valid_d = 1'b0;
      instr_d     = '0;
      npc_d       = '0;
    end else begin
      if (en) begin
        instr_d = avail ? avail_word : '0;
        npc_d   = avail ? avail_npc : '0;
      end
      if (fetch_hit) pc_d = pc_plus4;
      // decode stalled: park the returned word so the request is not lost
      if (fetch_hit && !en) begin
        buf_word_d  = imemload;
        buf_npc_d   = pc_plus4;
        buf_valid_d = 1'b1;
        state_d     = BUF;
      end
      if (state_q == BUF && en) begin
        buf_valid_d = 1'b0;
        state_d     = FETCH;
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
      buf_word_q  <= '0;
      buf_npc_q   <= '0;
      buf_valid_q <= 1'b0;
      instr_q     <= '0;
      npc_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_word_q  <= buf_word_d;
      buf_npc_q   <= buf_npc_d;
      buf_valid_q <= buf_valid_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        en = 1'b0, jump_instr = 1'b0, branch_taken = 1'b0, halt = 1'b0, ihit = 1'b0;
  logic [31:0] jump_target = '0, branch_target = '0, imemload = '0;
  logic        ren1, ren2;
  logic [31:0] addr1, addr2;
  int          n_checks = 0, n_fail = 0;
  fetch_decode_if fd1 ();
  fetch_decode_if fd2 ();
  fetch_stage dut1 (
    .CLK(CLK), .nRST(nRST), .en(en), .jump_instr(jump_instr), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .imemREN(ren1), .imemaddr(addr1), .ihit(ihit), .imemload(imemload), .out(fd1.fetch)
  );
  fetch_stage #(.PC_INIT(32'hFFFFFFFC)) dut2 (
    .CLK(CLK), .nRST(nRST), .en(en), .jump_instr(jump_instr), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .imemREN(ren2), .imemaddr(addr2), .ihit(ihit), .imemload(imemload), .out(fd2.fetch)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic check_out(input string tag, input logic [31:0] i, input logic [31:0] n);
    check({tag, ".instr"}, fd1.instruction, i);
    check({tag, ".npc"}, fd1.instr_npc, n);
  endtask
  initial begin
    #2;
    check("rst.addr", addr1, 32'h0);
    check("rst.ren", {31'b0, ren1}, 32'h1);
    check_out("rst", 32'h0, 32'h0);
    nRST = 1'b1;
    en = 1'b1; ihit = 1'b1; imemload = 32'h11;
    check("seq.addr0", addr1, 32'h0);
    step(); check_out("seq1", 32'h11, 32'h4); check("seq.addr4", addr1, 32'h4);
    imemload = 32'h22;
    step(); check_out("seq2", 32'h22, 32'h8); check("seq.addr8", addr1, 32'h8);
    imemload = 32'h33;
    step(); check_out("seq3", 32'h33, 32'hC);
    ihit = 1'b0; jump_instr = 1'b1; jump_target = 32'h40;
    step(); check_out("jmp40", 32'h0, 32'h0); check("jmp40.addr", addr1, 32'h40);
    jump_instr = 1'b0; en = 1'b0; ihit = 1'b1; imemload = 32'hAB;
    step(); check("buf.ren", {31'b0, ren1}, 32'h0); check("buf.addr", addr1, 32'h44);
    check_out("buf.hold", 32'h0, 32'h0);
    en = 1'b1; ihit = 1'b0;
    step(); check_out("buf.drain", 32'hAB, 32'h44);
    check("drain.ren", {31'b0, ren1}, 32'h1); check("drain.addr", addr1, 32'h44);
    en = 1'b0;
    step(); check_out("stall.hold", 32'hAB, 32'h44); check("stall.addr", addr1, 32'h44);
    en = 1'b1; jump_instr = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h200; ihit = 1'b1; imemload = 32'hDEAD;
    step(); check("prio.addr", addr1, 32'h200); check_out("prio", 32'h0, 32'h0);
    branch_taken = 1'b0; ihit = 1'b0; jump_target = 32'h80;
    step(); check("midreq.addr", addr1, 32'h80); check("midreq.ren", {31'b0, ren1}, 32'h1);
    jump_instr = 1'b0;
    step(); check_out("bubble", 32'h0, 32'h0); check("bubble.addr", addr1, 32'h80);
    ihit = 1'b1; imemload = 32'h77;
    step(); check_out("land", 32'h77, 32'h84); check("land.addr", addr1, 32'h84);
    en = 1'b0; ihit = 1'b0; jump_instr = 1'b1; jump_target = 32'h300;
    step(); check("noen.redir", addr1, 32'h84); check_out("noen", 32'h77, 32'h84);
    jump_instr = 1'b0; halt = 1'b1;
    step(); check("noen.halt", {31'b0, ren1}, 32'h1);
    en = 1'b1;
    step(); check("halt.ren", {31'b0, ren1}, 32'h0); check_out("halt", 32'h0, 32'h0);
    halt = 1'b0; jump_instr = 1'b1; jump_target = 32'h500; ihit = 1'b1; imemload = 32'h99;
    step(); check("halt.jmp.addr", addr1, 32'h84); check("halt.jmp.ren", {31'b0, ren1}, 32'h0);
    check_out("halt.jmp", 32'h0, 32'h0);
    step(); check("halt.stay", {31'b0, ren1}, 32'h0);
    jump_instr = 1'b0; ihit = 1'b0;
    #2 nRST = 1'b0;
    #1 check("rst2.addr", addr1, 32'h0); check("rst2.ren", {31'b0, ren1}, 32'h1);
    check("rst2.addr2", addr2, 32'hFFFFFFFC);
    #1 nRST = 1'b1;
    ihit = 1'b1; imemload = 32'h5;
    step();
    check("wrap.instr", fd2.instruction, 32'h5); check("wrap.npc", fd2.instr_npc, 32'h0);
    check("wrap.addr", addr2, 32'h0); check_out("nowrap", 32'h5, 32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: PC_INIT, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: en  input  1  pipeline advance; fetch/decode latch and PC redirect act only when high.
REQ-005 SHALL have port: jump_instr  input  1  decode-stage jump/JR resolved this cycle.
REQ-006 SHALL have port: jump_target  input  32  target for jump_instr.
REQ-007 SHALL have port: branch_taken  input  1  execute-stage branch resolved taken.
REQ-008 SHALL have port: branch_target  input  32  target for branch_taken.
REQ-009 SHALL have port: halt  input  1  halt decoded; stop fetching.
REQ-010 SHALL have port: imemREN  output  1  instruction read request.
REQ-011 SHALL have port: imemaddr  output  32  instruction address (= PC).
REQ-012 SHALL have port: ihit  input  1  imemload valid this cycle.
REQ-013 SHALL have port: imemload  input  32  instruction word.
REQ-014 SHALL have port: out  fetch_decode_if.fetch  --  registered instruction (32) and instr_npc (32) to decode.

Function
REQ-015 SHALL hold PC register, one-entry fetch buffer (word, npc, valid), and state in {FETCH, BUF, HALTED}.
REQ-016 SHALL drive imemREN=1, imemaddr=PC in FETCH; imemREN=0 in BUF and HALTED (imemaddr=PC).
REQ-017 SHALL define redirect = en & (branch_taken | jump_instr); target = branch_target if branch_taken else jump_target (branch priority).
REQ-018 SHALL define word available = (FETCH & ihit) or (BUF); avail word = imemload or buffered word respectively.
REQ-019 SHALL on redirect: PC<=target, buffer cleared, discard any word arriving this cycle, out.instruction<=0, out.instr_npc<=0, state<=FETCH.
REQ-020 SHALL on en & halt & !redirect: state<=HALTED, out.instruction<=0, out.instr_npc<=0, buffer cleared; halt has no effect when en=0.
REQ-021 SHALL in FETCH, no redirect/halt, ihit & en: out.instruction<=imemload, out.instr_npc<=PC+4, PC<=PC+4, stay FETCH.
REQ-022 SHALL in FETCH, ihit & !en: buffer<=(imemload, PC+4), PC<=PC+4, state<=BUF; out unchanged.
REQ-023 SHALL in FETCH, !ihit & en: out.instruction<=0, out.instr_npc<=0 (bubble); PC unchanged.
REQ-024 SHALL in FETCH, !ihit & !en: hold all state and outputs.
REQ-025 SHALL in BUF & en (no redirect/halt): out<=buffer contents, buffer cleared, state<=FETCH; !en: hold.
REQ-026 SHALL in HALTED: keep PC, out bubble on en, ignore redirect/ihit; exit only via reset.
REQ-027 SHALL compute PC+4 modulo 2^32 (0xFFFFFFFC+4 = 0).
REQ-028 SHALL change imemaddr mid-request (ihit=0) when redirected; prior request abandoned.
REQ-029 SHALL latency: word with ihit at edge N appears on out after edge N when en=1; max one buffered word.

Reset
REQ-030 SHALL on nRST low, immediately: PC=PC_INIT, state=FETCH, buffer invalid, out.instruction=0, out.instr_npc=0.
REQ-031 SHALL after release, assert imemREN=1, imemaddr=PC_INIT in first cycle; reset mid-request discards the request.

Verification
REQ-032 SHALL cover: reset, en=1, ihit=1 every cycle, words 0x11,0x22,0x33 -> imemaddr 0,4,8; out (0x11,4),(0x22,8),(0x33,12) on successive edges.
REQ-033 SHALL cover: ihit with en=0 at PC=0x40 word 0xAB -> BUF, imemREN=0, PC=0x44; next en=1 -> out (0xAB,0x44), imemREN=1 addr 0x44.
REQ-034 SHALL cover: jump_instr=1 target 0x100 and branch_taken=1 target 0x200 same cycle, en=1 -> PC=0x200, out bubble (0,0).
REQ-035 SHALL cover: redirect to 0x80 while ihit=0 -> next cycle imemaddr=0x80; later ihit word lands at out with npc 0x84.
REQ-036 SHALL cover: halt=1 en=1 -> imemREN=0 forever, out=0; subsequent jump_instr ignored; nRST pulse -> imemaddr=PC_INIT, imemREN=1.
REQ-037 SHALL cover: PC_INIT=0xFFFFFFFC, ihit word 0x5 en=1 -> out (0x5,0x0), next imemaddr=0.
